// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared definitions for the keypad matrix scanner: geometry, key codes,
// scan FSM states and the row/column-to-key-code map.
package keypad_matrix_scanner_pkg;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 3;
  localparam int unsigned KEYS   = 10;
  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] KEY_STAR = 4'd10;
  localparam logic [CODE_W-1:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_e;

  // r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#
  function automatic logic [CODE_W-1:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [CODE_W-1:0] code;
    code = 4'd0;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

  // Lowest-index active-low column; only meaningful when at least one bit is low.
  function automatic logic [1:0] first_low_col(input logic [COLS-1:0] col_n);
    logic [1:0] col;
    col = 2'd2;
    if (!col_n[1]) col = 2'd1;
    if (!col_n[0]) col = 2'd0;
    return col;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Keypad pins plus decoded key outputs; master is the scanner, slave is the
// keypad/controller side.
interface keypad_matrix_scanner_if;
  import keypad_matrix_scanner_pkg::*;

  logic [COLS-1:0]   col_n;
  logic [ROWS-1:0]   row_n;
  logic [KEYS-1:0]   keyboard;
  logic              key_start_n;
  logic              key_clear_n;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;

  modport master (
    input  col_n,
    output row_n, keyboard, key_start_n, key_clear_n, key_valid, key_code
  );

  modport slave (
    output col_n,
    input  row_n, keyboard, key_start_n, key_clear_n, key_valid, key_code
  );

endinterface

// File: rtl/keypad_matrix_scanner_sync_2ff.sv
// Two-stage synchroniser for asynchronous level inputs.
module keypad_matrix_scanner_sync_2ff #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x3 keypad scanner: row drive, column synchronise/debounce, one-hot digit
// level plus start/clear levels, valid pulse and last key code.
module keypad_matrix_scanner
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    clear,
  keypad_matrix_scanner_if.master bus
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV) + 1;
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX  = '1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_MAX   = '1;

  scan_state_e       r_state,    w_state_nxt;
  logic [1:0]        r_row,      w_row_nxt;
  logic [ROWS-1:0]   r_row_n,    w_row_n_nxt;
  logic [1:0]        r_col,      w_col_nxt;
  logic [SCAN_W-1:0] r_scan_cnt, w_scan_cnt_nxt;
  logic [DEB_W-1:0]  r_deb_cnt,  w_deb_cnt_nxt;
  logic [KEYS-1:0]   r_keyboard, w_keyboard_nxt;
  logic              r_start_n,  w_start_n_nxt;
  logic              r_clear_n,  w_clear_n_nxt;
  logic              r_valid,    w_valid_nxt;
  logic [CODE_W-1:0] r_code,     w_code_nxt;

  logic [COLS-1:0]   w_col_s;
  logic              w_col_low;
  logic [CODE_W-1:0] w_key;

  keypad_matrix_scanner_sync_2ff #(
    .WIDTH   (COLS),
    .RST_VAL ({COLS{1'b1}})
  ) u_col_sync (
    .clk (clk),
    .rst (clear),
    .i_d (bus.col_n),
    .o_q (w_col_s)
  );

  assign w_col_low = ~w_col_s[r_col];
  assign w_key     = key_map(r_row, r_col);

  // State and output registers
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state    <= ST_SCAN;
      r_row      <= 2'd0;
      r_row_n    <= 4'b1110;
      r_col      <= 2'd0;
      r_scan_cnt <= '0;
      r_deb_cnt  <= '0;
      r_keyboard <= '0;
      r_start_n  <= 1'b1;
      r_clear_n  <= 1'b1;
      r_valid    <= 1'b0;
      r_code     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_row_n    <= w_row_n_nxt;
      r_col      <= w_col_nxt;
      r_scan_cnt <= w_scan_cnt_nxt;
      r_deb_cnt  <= w_deb_cnt_nxt;
      r_keyboard <= w_keyboard_nxt;
      r_start_n  <= w_start_n_nxt;
      r_clear_n  <= w_clear_n_nxt;
      r_valid    <= w_valid_nxt;
      r_code     <= w_code_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_col_nxt      = r_col;
    w_scan_cnt_nxt = r_scan_cnt;
    w_deb_cnt_nxt  = r_deb_cnt;
    w_keyboard_nxt = r_keyboard;
    w_start_n_nxt  = r_start_n;
    w_clear_n_nxt  = r_clear_n;
    w_valid_nxt    = 1'b0;
    w_code_nxt     = r_code;

    case (r_state)
      ST_SCAN: begin
        if (r_scan_cnt == SCAN_LAST) begin
          w_scan_cnt_nxt = '0;
          if (w_col_s != {COLS{1'b1}}) begin
            w_col_nxt     = first_low_col(w_col_s);
            w_deb_cnt_nxt = '0;
            w_state_nxt   = ST_DEBOUNCE;
          end else begin
            w_row_nxt = r_row + 2'd1;
          end
        end else if (r_scan_cnt != SCAN_MAX) begin
          w_scan_cnt_nxt = r_scan_cnt + SCAN_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (!w_col_low) begin
          w_state_nxt    = ST_SCAN;
          w_row_nxt      = r_row + 2'd1;
          w_scan_cnt_nxt = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt    = ST_HELD;
          w_deb_cnt_nxt  = '0;
          w_valid_nxt    = 1'b1;
          w_code_nxt     = w_key;
          w_keyboard_nxt = (w_key < 4'd10) ? (KEYS'(1) << w_key) : '0;
          w_start_n_nxt  = (w_key != KEY_HASH);
          w_clear_n_nxt  = (w_key != KEY_STAR);
        end else if (r_deb_cnt != DEB_MAX) begin
          w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
        end
      end

      ST_HELD: begin
        if (!w_col_low) begin
          w_state_nxt   = ST_RELEASE;
          w_deb_cnt_nxt = '0;
        end
      end

      ST_RELEASE: begin
        if (w_col_low) begin
          w_state_nxt = ST_HELD;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt    = ST_SCAN;
          w_row_nxt      = r_row + 2'd1;
          w_scan_cnt_nxt = '0;
          w_deb_cnt_nxt  = '0;
          w_keyboard_nxt = '0;
          w_start_n_nxt  = 1'b1;
          w_clear_n_nxt  = 1'b1;
        end else if (r_deb_cnt != DEB_MAX) begin
          w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_SCAN;
      end
    endcase

    w_row_n_nxt = ~(ROWS'(1) << w_row_nxt);
  end

  assign bus.row_n       = r_row_n;
  assign bus.keyboard    = r_keyboard;
  assign bus.key_start_n = r_start_n;
  assign bus.key_clear_n = r_clear_n;
  assign bus.key_valid   = r_valid;
  assign bus.key_code    = r_code;

endmodule
